// File: rtl/img_pkg.sv
// Shared pixel/window types and the packing rule for 5x5 windows.
package img_pkg;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned WIN_N = 5;
    localparam int unsigned WIN_W = WIN_N * WIN_N * PIX_W;
    localparam int unsigned LB_N  = WIN_N - 1;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [WIN_W-1:0] win_t;

    // Bit offset of pixel (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int unsigned idx(input int unsigned r, input int unsigned c);
        return (WIN_N * r + c) * PIX_W;
    endfunction

endpackage

// File: rtl/window_5x5_gen_if.sv
// Pixel-in / window-out stream bundle of window_5x5_gen.
interface window_5x5_gen_if #(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64
);
    import img_pkg::*;

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    pix_t          pix_in;
    logic          in_valid;
    logic          in_ready;
    win_t          window_out;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] win_row;
    logic [CW-1:0] win_col;
    logic          frame_last;

    modport master (
        output pix_in, in_valid, out_ready,
        input  in_ready, window_out, out_valid, win_row, win_col, frame_last
    );

    modport slave (
        input  pix_in, in_valid, out_ready,
        output in_ready, window_out, out_valid, win_row, win_col, frame_last
    );

endinterface

// File: rtl/line_buffer_ram.sv
// One image row of pixels: synchronous write, asynchronous read (read-before-write).
module line_buffer_ram
    import img_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  pix_t          wdata,
    output pix_t          rdata
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/window_5x5_gen.sv
// Raster-order pixel stream in, one 5x5 neighbourhood out per fully-interior pixel position.
module window_5x5_gen
    import img_pkg::*;
#(
    parameter int unsigned IMG_W = 64,
    parameter int unsigned IMG_H = 64,
    localparam int unsigned CW = $clog2(IMG_W),
    localparam int unsigned RW = $clog2(IMG_H)
) (
    input logic             clk,
    input logic             rst,
    window_5x5_gen_if.slave bus
);

    logic          accept, emit, col_last, row_last;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    win_t          win_q, win_d;
    logic          out_valid_q, out_valid_d;
    logic          frame_last_q, frame_last_d;
    logic [RW-1:0] win_row_q, win_row_d;
    logic [CW-1:0] win_col_q, win_col_d;
    pix_t          lb_rd [LB_N];
    pix_t          lb_wr [LB_N];
    pix_t          col_vec [WIN_N];

    assign bus.in_ready = !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign col_last     = col_q == CW'(IMG_W - 1);
    assign row_last     = row_q == RW'(IMG_H - 1);
    assign emit         = (row_q >= RW'(WIN_N - 1)) && (col_q >= CW'(WIN_N - 1));

    // lb[0] holds the previous row; each accept pushes the column one buffer deeper.
    for (genvar k = 0; k < LB_N; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign lb_wr[k] = bus.pix_in;
        end else begin : g_tail
            assign lb_wr[k] = lb_rd[k-1];
        end
        assign col_vec[LB_N-1-k] = lb_rd[k];

        line_buffer_ram #(
            .DEPTH (IMG_W)
        ) u_ram (
            .clk   (clk),
            .we    (accept),
            .addr  (col_q),
            .wdata (lb_wr[k]),
            .rdata (lb_rd[k])
        );
    end
    assign col_vec[WIN_N-1] = bus.pix_in;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        out_valid_d  = out_valid_q && !bus.out_ready;
        frame_last_d = frame_last_q && out_valid_d;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        if (accept) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
                row_d = row_last ? '0 : row_q + RW'(1);
            end
            for (int r = 0; r < WIN_N; r++) begin
                for (int c = 0; c < WIN_N - 1; c++) begin
                    win_d[idx(r, c) +: PIX_W] = win_q[idx(r, c + 1) +: PIX_W];
                end
                win_d[idx(r, WIN_N - 1) +: PIX_W] = col_vec[r];
            end
            // Accept implies any pending window is consumed this cycle.
            out_valid_d  = emit;
            frame_last_d = emit && col_last && row_last;
            win_row_d    = row_q;
            win_col_d    = col_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            out_valid_q  <= 1'b0;
            frame_last_q <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            out_valid_q  <= out_valid_d;
            frame_last_q <= frame_last_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
        end
    end

    assign bus.window_out = win_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.frame_last = frame_last_q;
    assign bus.win_row    = win_row_q;
    assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_window_5x5_gen.sv
// Bench: a 5x5-image and an 8x6-image instance checked every cycle against a pixel-array model.
module tb_window_5x5_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst5, rst86;
    logic [7:0] drv_pix [2];
    logic       drv_valid [2];
    logic       drv_ready [2];
    bit         rdy_rand [2];
    logic       ir_a [2];
    logic       ov_a [2];

    window_5x5_gen_if #(.IMG_W(5), .IMG_H(5)) if5 ();
    window_5x5_gen_if #(.IMG_W(8), .IMG_H(6)) if86 ();

    window_5x5_gen #(.IMG_W(5), .IMG_H(5)) u_dut5 (.clk(clk), .rst(rst5), .bus(if5.slave));
    window_5x5_gen #(.IMG_W(8), .IMG_H(6)) u_dut86 (.clk(clk), .rst(rst86), .bus(if86.slave));

    assign if5.pix_in     = drv_pix[0];
    assign if5.in_valid   = drv_valid[0];
    assign if5.out_ready  = drv_ready[0];
    assign if86.pix_in    = drv_pix[1];
    assign if86.in_valid  = drv_valid[1];
    assign if86.out_ready = drv_ready[1];
    assign ir_a[0] = if5.in_ready;
    assign ir_a[1] = if86.in_ready;
    assign ov_a[0] = if5.out_valid;
    assign ov_a[1] = if86.out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: the current frame's pixels plus at most one expected window in flight.
    logic [7:0]   img [2][8][8];
    int           cnt [2];
    bit           exp_v [2];
    logic [199:0] exp_win [2];
    int           exp_row [2], exp_col [2];
    bit           exp_last [2];
    bit           stall_prev [2];
    logic [199:0] prev_win [2];
    int           cons [2];
    int           cap_n [2];
    int           cap_row [2][32], cap_col [2][32];
    bit           cap_last [2][32];
    logic [199:0] cap_win [2][32];

    function automatic int wd(input int id);
        return (id == 0) ? 5 : 8;
    endfunction

    function automatic int ht(input int id);
        return (id == 0) ? 5 : 6;
    endfunction

    task automatic check(input string name, input int id, input logic [199:0] act,
                         input logic [199:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, want %h", name, id, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name, input int id);
        n_tests++;
        n_fail++;
        $display("FAIL %s dut%0d: timed out, got no handshake, want one", name, id);
    endtask

    task automatic mon(input int id, input bit r, input bit iv, input bit ir, input logic [7:0] px,
                       input bit ov, input bit ordy, input logic [199:0] win, input int wr,
                       input int wc, input bit fl);
        int pos, row, col;
        if (r) begin
            exp_v[id]      = 1'b0;
            cnt[id]        = 0;
            stall_prev[id] = 1'b0;
            return;
        end
        check("out_valid", id, 200'(ov), 200'(exp_v[id]));
        check("in_ready", id, 200'(ir), 200'(!ov || ordy));
        if (stall_prev[id]) check("stall_window", id, win, prev_win[id]);
        if (ov && exp_v[id]) begin
            check("window", id, win, exp_win[id]);
            check("win_row", id, 200'(wr), 200'(exp_row[id]));
            check("win_col", id, 200'(wc), 200'(exp_col[id]));
            check("frame_last", id, 200'(fl), 200'(exp_last[id]));
        end
        stall_prev[id] = ov && !ordy;
        prev_win[id]   = win;
        if (ov && ordy) begin
            exp_v[id] = 1'b0;
            cons[id]++;
            if (cap_n[id] < 32) begin
                cap_row[id][cap_n[id]]  = wr;
                cap_col[id][cap_n[id]]  = wc;
                cap_last[id][cap_n[id]] = fl;
                cap_win[id][cap_n[id]]  = win;
                cap_n[id]++;
            end
        end
        if (iv && ir) begin
            pos = cnt[id];
            row = pos / wd(id);
            col = pos % wd(id);
            img[id][row][col] = px;
            cnt[id] = (pos + 1) % (wd(id) * ht(id));
            if (row >= 4 && col >= 4) begin
                exp_v[id]    = 1'b1;
                exp_row[id]  = row;
                exp_col[id]  = col;
                exp_last[id] = (row == ht(id) - 1) && (col == wd(id) - 1);
                for (int rr = 0; rr < 5; rr++) begin
                    for (int cc = 0; cc < 5; cc++) begin
                        exp_win[id][(5 * rr + cc) * 8 +: 8] = img[id][row - 4 + rr][col - 4 + cc];
                    end
                end
            end
        end
    endtask

    always @(negedge clk) mon(0, rst5, if5.in_valid, if5.in_ready, if5.pix_in, if5.out_valid,
                              if5.out_ready, if5.window_out, int'(if5.win_row),
                              int'(if5.win_col), if5.frame_last);
    always @(negedge clk) mon(1, rst86, if86.in_valid, if86.in_ready, if86.pix_in,
                              if86.out_valid, if86.out_ready, if86.window_out,
                              int'(if86.win_row), int'(if86.win_col), if86.frame_last);

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rdy_rand[i]) drv_ready[i] = 1'($urandom_range(0, 1));
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic send_px(input int id, input logic [7:0] px, input bit rnd);
        int t = 0;
        if (rnd) begin
            while ($urandom_range(0, 1) == 0) begin
                drv_valid[id] = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        drv_valid[id] = 1'b1;
        drv_pix[id]   = px;
        forever begin
            @(negedge clk);
            if (ir_a[id]) break;
            t++;
            if (t > 200) begin
                timeout_fail("accept", id);
                break;
            end
        end
        @(posedge clk);
        #1;
        drv_valid[id] = 1'b0;
    endtask

    task automatic send_frame(input int id, input int mode, input bit rnd);
        for (int r = 0; r < ht(id); r++) begin
            for (int c = 0; c < wd(id); c++) begin
                logic [7:0] p;
                case (mode)
                    0:       p = 8'(16 * r + c);
                    1:       p = 8'(255 - 16 * r - c);
                    2:       p = 8'($urandom);
                    default: p = 8'(5 * r + c);
                endcase
                send_px(id, p, rnd);
            end
        end
    endtask

    task automatic drain(input int id);
        int t = 0;
        forever begin
            @(negedge clk);
            if (!ov_a[id]) break;
            t++;
            if (t > 100) begin
                timeout_fail("drain", id);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // 8x6 image: windows at rows 4..5, columns 4..7, in raster order.
    task automatic check_order(input int nf);
        check("win_count", 1, 200'(cap_n[1]), 200'(8 * nf));
        for (int i = 0; i < 8 * nf && i < cap_n[1]; i++) begin
            check("order_row", 1, 200'(cap_row[1][i]), 200'(4 + (i % 8) / 4));
            check("order_col", 1, 200'(cap_col[1][i]), 200'(4 + i % 4));
            check("order_last", 1, 200'(cap_last[1][i]), 200'(i % 8 == 7));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] lit;
        int           c0;
        for (int i = 0; i < 2; i++) begin
            drv_pix[i] = '0; drv_valid[i] = 1'b0; drv_ready[i] = 1'b1; rdy_rand[i] = 1'b0;
            cnt[i] = 0; exp_v[i] = 1'b0; stall_prev[i] = 1'b0; cons[i] = 0; cap_n[i] = 0;
        end
        rst5 = 1'b1;
        rst86 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst5 = 1'b0;
        rst86 = 1'b0;
        @(negedge clk);
        check("reset_valid", 0, 200'(ov_a[0]), 200'(0));
        check("reset_ready", 1, 200'(ir_a[1]), 200'(1));
        check("reset_window", 1, if86.window_out, 200'(0));
        @(posedge clk);
        #1;
        fork
            begin
                // 5x5 image, pixels 0..24: a single window with byte k = k.
                cap_n[0] = 0;
                send_frame(0, 3, 1'b0);
                drain(0);
                for (int k = 0; k < 25; k++) lit[8 * k +: 8] = 8'(k);
                check("t1_count", 0, 200'(cap_n[0]), 200'(1));
                check("t1_window", 0, cap_win[0][0], lit);
                check("t1_row", 0, 200'(cap_row[0][0]), 200'(4));
                check("t1_col", 0, 200'(cap_col[0][0]), 200'(4));
                check("t1_last", 0, 200'(cap_last[0][0]), 200'(1));
                c0 = cons[0];
                rdy_rand[0] = 1'b1;
                repeat (600) send_frame(0, 2, 1'b1);
                rdy_rand[0] = 1'b0;
                drv_ready[0] = 1'b1;
                drain(0);
                check("t6_count5", 0, 200'(cons[0] - c0), 200'(600));
            end
            begin
                int c1;
                cap_n[1] = 0;
                send_frame(1, 0, 1'b0);
                drain(1);
                check_order(1);
                check("t2_first_00", 1, 200'(cap_win[1][0][7:0]), 200'(8'h00));
                check("t2_first_44", 1, 200'(cap_win[1][0][199:192]), 200'(8'h44));
                check("t2_last_00", 1, 200'(cap_win[1][7][7:0]), 200'(8'h13));
                check("t2_last_44", 1, 200'(cap_win[1][7][199:192]), 200'(8'h57));

                cap_n[1] = 0;
                drv_ready[1] = 1'b0;
                fork
                    send_frame(1, 0, 1'b0);
                    begin
                        int t = 0;
                        do begin
                            @(negedge clk);
                            t++;
                        end while (!ov_a[1] && t < 200);
                        if (!ov_a[1]) timeout_fail("t3_window", 1);
                        for (int i = 0; i < 3; i++) begin
                            if (i > 0) @(negedge clk);
                            check("t3_in_ready", 1, 200'(ir_a[1]), 200'(0));
                            check("t3_valid", 1, 200'(ov_a[1]), 200'(1));
                        end
                        @(posedge clk);
                        #1;
                        drv_ready[1] = 1'b1;
                    end
                join
                drain(1);
                check_order(1);

                cap_n[1] = 0;
                send_frame(1, 0, 1'b0);
                send_frame(1, 1, 1'b0);
                drain(1);
                check_order(2);
                check("t4_b_first", 1, 200'(cap_win[1][8][7:0]), 200'(8'hFF));

                cap_n[1] = 0;
                for (int i = 0; i < 20; i++) send_px(1, 8'(7 * i), 1'b0);
                rst86 = 1'b1;
                @(posedge clk);
                #1;
                rst86 = 1'b0;
                @(negedge clk);
                check("t5_valid", 1, 200'(ov_a[1]), 200'(0));
                check("t5_ready", 1, 200'(ir_a[1]), 200'(1));
                @(posedge clk);
                #1;
                send_frame(1, 0, 1'b0);
                drain(1);
                check_order(1);

                // Reset while a window is pending and stalled.
                drv_ready[1] = 1'b0;
                for (int i = 0; i < 37; i++) send_px(1, 8'($urandom), 1'b0);
                @(negedge clk);
                check("pend_valid", 1, 200'(ov_a[1]), 200'(1));
                @(posedge clk);
                #1;
                rst86 = 1'b1;
                @(posedge clk);
                #1;
                rst86 = 1'b0;
                drv_ready[1] = 1'b1;
                @(negedge clk);
                check("pend_rst_valid", 1, 200'(ov_a[1]), 200'(0));
                check("pend_rst_last", 1, 200'(if86.frame_last), 200'(0));
                check("pend_rst_row", 1, 200'(if86.win_row), 200'(0));
                check("pend_rst_col", 1, 200'(if86.win_col), 200'(0));
                check("pend_rst_window", 1, if86.window_out, 200'(0));
                @(posedge clk);
                #1;

                c1 = cons[1];
                rdy_rand[1] = 1'b1;
                repeat (150) send_frame(1, 2, 1'b1);
                rdy_rand[1] = 1'b0;
                drv_ready[1] = 1'b1;
                drain(1);
                check("t6_count86", 1, 200'(cons[1] - c1), 200'(150 * 8));
            end
        join
        check("end_idle5", 0, 200'(exp_v[0]), 200'(0));
        check("end_idle86", 1, 200'(exp_v[1]), 200'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
